// File: rtl/featuremap_serial_accum_if.sv
// Handshake bundle for featuremap_serial_accum.
//   Input side : in_valid/in_ready handshake, in_data carries NUM_CH packed
//                fp32 partial sums (channel c at [c*DATA_WIDTH +: DATA_WIDTH]),
//                relu_en is sampled together with the accepted pixel.
//   Output side: out_valid/out_ready handshake, out_data is the fp32 pixel,
//                out_last marks the final pixel of a feature map.
// Modports: slave  = the accumulator block itself
//           master = the environment that feeds it and drains it
interface featuremap_serial_accum_if #(
   parameter int DATA_WIDTH = 32,
   parameter int NUM_CH     = 16
);
   logic                         in_valid;
   logic                         in_ready;
   logic [NUM_CH*DATA_WIDTH-1:0] in_data;
   logic                         relu_en;
   logic                         out_valid;
   logic                         out_ready;
   logic [DATA_WIDTH-1:0]        out_data;
   logic                         out_last;

   modport slave (
      input  in_valid, in_data, relu_en, out_ready,
      output in_ready, out_valid, out_data, out_last
   );

   modport master (
      output in_valid, in_data, relu_en, out_ready,
      input  in_ready, out_valid, out_data, out_last
   );
endinterface

// File: rtl/featuremap_serial_accum.sv
// Feature-map output stage with a single time-multiplexed fp32 adder.
// One accepted pixel carries NUM_CH per-channel partial sums; the block
// computes ((BIAS+ch0)+ch1)+...+ch[NUM_CH-1], optionally applies ReLU and
// presents the result on the output handshake, flagging the last pixel of
// each PIXELS-long feature map.
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous, active-low reset
//   bus  - slave side of featuremap_serial_accum_if (in/out handshakes)
//   busy - high whenever the block is not idle
module featuremap_serial_accum #(
   parameter int                    DATA_WIDTH = 32,
   parameter int                    NUM_CH     = 16,
   parameter logic [DATA_WIDTH-1:0] BIAS       = 32'h00000000,
   parameter int                    PIXELS     = 3136
) (
   input  logic                     clk,
   input  logic                     rst,
   featuremap_serial_accum_if.slave bus,
   output logic                     busy
);

   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam int PIX_W = (PIXELS > 1) ? $clog2(PIXELS) : 1;

   typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

   // Combinational fp32 add: round-to-nearest-even, denormal inputs are
   // treated as zero and results below the normal range flush to zero.
   // Any NaN operand or inf-inf yields the canonical quiet NaN 7FC00000.
   function automatic logic [31:0] fp_add(input logic [31:0] a, input logic [31:0] b);
      logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
      logic        sx, sy;
      logic [7:0]  ex, ey, d;
      logic [22:0] fx, fy;
      logic [26:0] mx, my, my_sh;
      logic [27:0] sum;
      logic [24:0] mant;
      logic [4:0]  lz;
      logic        found;
      int          er;

      a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
      b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
      a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
      b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
      a_zero = (a[30:23] == 8'h00);
      b_zero = (b[30:23] == 8'h00);

      if (a_nan || b_nan || (a_inf && b_inf && (a[31] != b[31]))) return 32'h7FC00000;
      if (a_inf) return a;
      if (b_inf) return b;
      if (a_zero && b_zero) return {a[31] & b[31], 31'd0};
      if (a_zero) return b;
      if (b_zero) return a;

      // x is the operand with the larger magnitude; its sign wins.
      if (a[30:0] >= b[30:0]) begin
         sx = a[31]; ex = a[30:23]; fx = a[22:0];
         sy = b[31]; ey = b[30:23]; fy = b[22:0];
      end else begin
         sx = b[31]; ex = b[30:23]; fx = b[22:0];
         sy = a[31]; ey = a[30:23]; fy = a[22:0];
      end

      // Hidden bit, 23 fraction bits, then guard/round/sticky.
      mx = {1'b1, fx, 3'b000};
      my = {1'b1, fy, 3'b000};
      d  = ex - ey;
      if (d >= 8'd27) begin
         my_sh = 27'd1;
      end else begin
         my_sh = my >> d;
         // Bits pushed out on the right collapse into the sticky bit.
         if (|(my << (8'd27 - d))) my_sh[0] = 1'b1;
      end

      er = int'(ex);
      if (sx == sy) begin
         sum = {1'b0, mx} + {1'b0, my_sh};
         if (sum[27]) begin
            sum = {1'b0, sum[27:2], sum[1] | sum[0]};
            er  = er + 1;
         end
      end else begin
         sum = {1'b0, mx} - {1'b0, my_sh};
         if (sum == 28'd0) return 32'h00000000;
         lz    = 5'd0;
         found = 1'b0;
         for (int i = 26; i >= 0; i--) begin
            if (!found) begin
               if (sum[i]) found = 1'b1;
               else        lz    = lz + 5'd1;
            end
         end
         sum = sum << lz;
         er  = er - int'(lz);
      end

      if (er <= 0) return {sx, 31'd0};

      mant = {1'b0, sum[26:3]};
      if (sum[2] && (sum[1] || sum[0] || sum[3])) mant = mant + 25'd1;
      if (mant[24]) begin
         mant = mant >> 1;
         er   = er + 1;
      end
      if (er >= 255) return {sx, 8'hFF, 23'd0};
      return {sx, 8'(er), mant[22:0]};
   endfunction

   state_t                       state_q, state_d;
   logic [NUM_CH*DATA_WIDTH-1:0] ch_buf_q, ch_buf_d;
   logic [DATA_WIDTH-1:0]        acc_q, acc_d;
   logic [IDX_W-1:0]             idx_q, idx_d;
   logic [PIX_W-1:0]             pix_q, pix_d;
   logic                         relu_q, relu_d;
   logic [DATA_WIDTH-1:0]        out_data_q, out_data_d;
   logic                         out_valid_q, out_valid_d;
   logic                         out_last_q, out_last_d;

   // Channel mux built as an AND-OR of per-channel selects.
   logic [DATA_WIDTH-1:0] ch_sel [NUM_CH];
   logic [DATA_WIDTH-1:0] cur_ch;
   logic [DATA_WIDTH-1:0] add_sum;
   logic [DATA_WIDTH-1:0] relu_out;
   logic                  last_ch;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_CH; gi++) begin : g_ch_sel
         assign ch_sel[gi] = (idx_q == IDX_W'(gi)) ? ch_buf_q[gi*DATA_WIDTH +: DATA_WIDTH]
                                                   : '0;
      end
   endgenerate

   always_comb begin
      cur_ch = '0;
      for (int i = 0; i < NUM_CH; i++) cur_ch = cur_ch | ch_sel[i];
   end

   assign add_sum  = fp_add(acc_q, cur_ch);
   // A set sign bit (including -0 and negative NaN) clamps to +0.
   assign relu_out = (relu_q && add_sum[DATA_WIDTH-1]) ? '0 : add_sum;
   assign last_ch  = (idx_q == IDX_W'(NUM_CH - 1));

   always_comb begin
      state_d     = state_q;
      ch_buf_d    = ch_buf_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      pix_d       = pix_q;
      relu_d      = relu_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      out_last_d  = out_last_q;

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               ch_buf_d = bus.in_data;
               relu_d   = bus.relu_en;
               acc_d    = BIAS;
               idx_d    = '0;
               state_d  = ACCUM;
            end
         end
         ACCUM: begin
            acc_d = add_sum;
            idx_d = idx_q + 1'b1;
            if (last_ch) begin
               idx_d       = '0;
               out_data_d  = relu_out;
               out_valid_d = 1'b1;
               out_last_d  = (pix_q == PIX_W'(PIXELS - 1));
               state_d     = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) begin
               out_valid_d = 1'b0;
               out_last_d  = 1'b0;
               pix_d       = (pix_q == PIX_W'(PIXELS - 1)) ? '0 : pix_q + 1'b1;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         ch_buf_q    <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         pix_q       <= '0;
         relu_q      <= 1'b0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         out_last_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         ch_buf_q    <= ch_buf_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         pix_q       <= pix_d;
         relu_q      <= relu_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         out_last_q  <= out_last_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign bus.out_last  = out_last_q;
   assign busy          = (state_q != IDLE);

endmodule
